// File: rtl/fetch_buf_unit.sv
// Fetch stage: owns the PC, issues one request at a time to a variable-latency
// instruction memory, and buffers returned instructions for decode.
module fetch_buf_unit #(
    parameter int ADDR_W   = 16,
    parameter int INST_W   = 16,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 2,
    parameter int RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_rdy,
    input  logic                         imem_valid,
    input  logic [INST_W-1:0]            imem_data,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    output logic                         inst_valid,
    output logic [INST_W-1:0]            inst_out,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic [ADDR_W-1:0]            inst_npc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              squash;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [INST_W-1:0] buf_inst [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];

    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              carry;
    logic [ADDR_W-1:0] pc_next;
    logic              misalign;
    logic [ADDR_W-1:0] head_pc;

    assign full      = (cnt == CW'(DEPTH));
    assign imem_req  = !rst && !halt && !redirect && !outstanding && !full;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_rdy;
    // A response is only kept if it belongs to the live stream
    assign push      = imem_valid && outstanding && !squash && !redirect;
    assign pop       = inst_valid && inst_ready && !redirect;
    assign {carry, pc_next} = {1'b0, pc} + (ADDR_W + 1)'(PC_INC);
    assign misalign  = |(redirect_pc & ADDR_W'(PC_INC - 1));

    assign inst_valid = (cnt != '0);
    assign count      = cnt;
    assign head_pc    = buf_pc[rd_ptr];
    assign inst_out   = inst_valid ? buf_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? head_pc : '0;
    assign inst_npc   = inst_valid ? head_pc + ADDR_W'(PC_INC) : '0;

    // Buffer storage; contents are never observed while the slot is empty
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end

    // Buffer pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // PC, request tracking and squash of a response from a flushed stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= ADDR_W'(RESET_PC);
            req_pc      <= '0;
            outstanding <= 1'b0;
            squash      <= 1'b0;
        end else begin
            if (redirect)    pc <= redirect_pc;
            else if (accept) pc <= pc_next;
            if (accept) req_pc <= pc;
            if (imem_valid) begin
                outstanding <= 1'b0;
                squash      <= 1'b0;
            end else if (redirect && outstanding) begin
                squash <= 1'b1;
            end
            if (accept) outstanding <= 1'b1;
        end
    end

    // Sticky error: PC wrap, unexpected response, misaligned target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((imem_valid && !outstanding) ||
                     (accept && carry) ||
                     (redirect && misalign)) begin
            err <= 1'b1;
        end
    end
endmodule

// File: doc/fetch_buf_unit.md
Name: fetch_buf_unit

Overview:
- Parametrised fetch stage that supersedes the single-cycle PC-plus-memory fetch.
- Owns the PC and issues instruction requests to a variable-latency instruction memory port (req/rdy, valid/data).
- Buffers returned instructions with their PC in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
- Supports branch redirect with flush, response squashing and fetch halt (createDump/HALT).

Parameters:
ADDR_W, 16, PC and memory address width
INST_W, 16, instruction width
DEPTH, 4, instruction buffer entries (power of 2, >=2)
PC_INC, 2, PC increment per fetched instruction (power of 2)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  request valid to instruction memory
imem_addr  output  ADDR_W  request address (current PC)
imem_rdy  input  1  memory accepts request this cycle
imem_valid  input  1  response data valid
imem_data  input  INST_W  response instruction
redirect  input  1  branch/jump resolved taken: flush and refetch
redirect_pc  input  ADDR_W  redirect target
halt  input  1  stop issuing new requests while high
inst_valid  output  1  buffer head valid to decode
inst_out  output  INST_W  head instruction
inst_pc  output  ADDR_W  PC of head instruction
inst_npc  output  ADDR_W  head PC + PC_INC
inst_ready  input  1  decode consumes head this cycle
count  output  log2(DEPTH)+1  buffer occupancy
err  output  1  sticky error

Behaviour:
- Reset (async, any time, including mid-request): PC=RESET_PC, FIFO empty, count=0, inst_valid=0, imem_req=0, outstanding=0, squash=0, err=0. Outputs inst_out, inst_pc and inst_npc are 0 while empty.
- Issue rule: imem_req = !halt & !redirect & !outstanding & (count < DEPTH). imem_addr = PC. At most one request is outstanding.
- Accept (imem_req & imem_rdy): outstanding<=1, req_pc<=PC, PC<=PC+PC_INC (mod 2^ADDR_W). A carry out of ADDR_W sets err.
- Response: imem_valid earliest 1 cycle after accept. If outstanding & !squash & !redirect: push {imem_data, req_pc} at tail. In all cases outstanding<=0 and squash<=0.
- imem_valid with outstanding=0 sets err and the data is dropped.
- Pop: inst_valid & inst_ready advances the head. Push and pop in the same cycle leave count unchanged.
- Push to a full buffer is impossible by the issue rule. Pop from empty is ignored.
- FIFO pointers wrap modulo DEPTH.
- Output latency: a response at edge N appears on inst_valid/inst_out after edge N (registered FIFO, no bypass). inst_npc = inst_pc + PC_INC.
- Redirect (single-cycle pulse, highest priority):
  - Next edge: FIFO emptied, count=0, PC<=redirect_pc.
  - A pop and any response in the redirect cycle are discarded.
  - If a request is outstanding and its response has not arrived, squash<=1 so that response is dropped.
  - No request is issued in the redirect cycle. Issue resumes the following cycle at redirect_pc (after the squashed response returns, if any).
- redirect_pc not a multiple of PC_INC: err set, redirect still performed.
- Halt: no new requests. An outstanding response still enqueues and the buffer keeps draining. PC holds. Deassert resumes at the held PC. Redirect during halt updates PC and flushes.
- err is sticky until rst.

Test Plan:
- Reset then imem_rdy=1, 1-cycle latency memory returning addr-derived data, inst_ready=1 -> inst_pc sequence 0,2,4,6 with matching data. inst_valid first high 3 cycles after reset release.
- inst_ready=0, DEPTH=4 -> count reaches 4, imem_req held 0, PC=8. Then one pop -> exactly one new request to 8, count returns to 4.
- Request to 0x0010 accepted, redirect to 0x0100 before response, response arrives next cycle -> response dropped, FIFO empty, next imem_addr=0x0100, first inst_pc=0x0100.
- Redirect in the same cycle as imem_valid and inst_ready with count=2 -> count=0 next cycle, no data for the old stream ever appears on inst_out.
- halt=1 with one request outstanding -> that response is enqueued, no further imem_req. halt=0 -> fetch resumes at the next sequential PC.
- PC=0xFFFE request accepted -> PC wraps to 0x0000, err=1 and stays 1. Spurious imem_valid after reset -> err=1. Redirect to 0x0003 -> err=1, PC=0x0003.
